// File: rtl/reaction_sequencer_pkg.sv
// Shared types for the reaction timer sequencer: FSM states and the 14-bit ms type.
package reaction_pkg;

    localparam int MS_W = 14;

    typedef logic [MS_W-1:0] ms_t;

    typedef enum logic [1:0] {IDLE, DELAY, LAMP, DONE} state_t;

    // Foreperiod in ms for a given LFSR sample; parameters guarantee it fits in MS_W bits.
    function automatic ms_t calc_target(input int base_ms, input int step_ms, input logic [3:0] rnd);
        return ms_t'(base_ms + 32'(rnd) * step_ms);
    endfunction

endpackage

// File: rtl/reaction_sequencer_if.sv
// Handshake/result bundle between the reaction sequencer and its surroundings.
interface reaction_sequencer_if;
    import reaction_pkg::*;

    logic start;
    logic btn;
    logic [3:0] rnd;
    logic lamp;
    logic busy;
    ms_t  time_ms;
    logic valid;
    logic false_start;
    logic timeout;

    modport master (
        output start, btn, rnd,
        input  lamp, busy, time_ms, valid, false_start, timeout
    );

    modport slave (
        input  start, btn, rnd,
        output lamp, busy, time_ms, valid, false_start, timeout
    );
endinterface

// File: rtl/reaction_sequencer_ms_prescaler.sv
// Divides clk down to a one-cycle ms_tick; the count restarts from zero whenever clear is high.
module ms_prescaler #(
    parameter int TICKS_PER_MS = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic ms_tick
);
    localparam int PRE_W = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_MS - 1);

    logic [PRE_W-1:0] pre_reg;

    // Tick is taken from the registered count so ms_cnt advances on the same edge pre wraps.
    assign ms_tick = en && !clear && (pre_reg == PRE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_reg <= '0;
        end else if (clear) begin
            pre_reg <= '0;
        end else if (en) begin
            pre_reg <= ms_tick ? '0 : pre_reg + 1'b1;
        end
    end
endmodule

// File: rtl/reaction_sequencer.sv
// Reaction timer sequencer: random foreperiod, lamp, reaction measurement, false start / timeout.
module reaction_sequencer
    import reaction_pkg::*;
#(
    parameter int TICKS_PER_MS = 50000,
    parameter int BASE_MS      = 1000,
    parameter int STEP_MS      = 250,
    parameter int MAX_MS       = 9999
) (
    input  logic clk,
    input  logic reset_n,
    reaction_sequencer_if.slave bus
);
    localparam ms_t MAX_T = ms_t'(MAX_MS);

    state_t state_reg;
    ms_t    ms_cnt_reg;
    ms_t    target_reg;
    ms_t    time_ms_reg;
    logic   lamp_reg;
    logic   busy_reg;
    logic   valid_reg;
    logic   false_start_reg;
    logic   timeout_reg;

    logic go_delay;
    logic go_lamp;
    logic clear;
    logic en;
    logic ms_tick;

    assign go_delay = bus.start && (state_reg == IDLE || state_reg == DONE);
    assign go_lamp  = (state_reg == DELAY) && !bus.btn && (ms_cnt_reg == target_reg);
    assign clear    = go_delay || go_lamp;
    assign en       = (state_reg == DELAY) || (state_reg == LAMP);

    ms_prescaler #(.TICKS_PER_MS(TICKS_PER_MS)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .en      (en),
        .ms_tick (ms_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            ms_cnt_reg      <= '0;
            target_reg      <= '0;
            time_ms_reg     <= '0;
            lamp_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            valid_reg       <= 1'b0;
            false_start_reg <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            if (clear) begin
                ms_cnt_reg <= '0;
            end else if (ms_tick) begin
                ms_cnt_reg <= ms_cnt_reg + 1'b1;
            end

            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_reg       <= DELAY;
                        target_reg      <= calc_target(BASE_MS, STEP_MS, bus.rnd);
                        busy_reg        <= 1'b1;
                        lamp_reg        <= 1'b0;
                        time_ms_reg     <= '0;
                        valid_reg       <= 1'b0;
                        false_start_reg <= 1'b0;
                        timeout_reg     <= 1'b0;
                    end
                end
                DELAY: begin
                    if (bus.btn) begin
                        state_reg       <= DONE;
                        busy_reg        <= 1'b0;
                        false_start_reg <= 1'b1;
                        time_ms_reg     <= '0;
                    end else if (ms_cnt_reg == target_reg) begin
                        state_reg <= LAMP;
                        lamp_reg  <= 1'b1;
                    end
                end
                LAMP: begin
                    // A press coinciding with the MAX_MS count still wins over the timeout.
                    if (bus.btn) begin
                        state_reg   <= DONE;
                        lamp_reg    <= 1'b0;
                        busy_reg    <= 1'b0;
                        valid_reg   <= 1'b1;
                        time_ms_reg <= ms_cnt_reg;
                    end else if (ms_cnt_reg == MAX_T) begin
                        state_reg   <= DONE;
                        lamp_reg    <= 1'b0;
                        busy_reg    <= 1'b0;
                        timeout_reg <= 1'b1;
                        time_ms_reg <= MAX_T;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.lamp        = lamp_reg;
    assign bus.busy        = busy_reg;
    assign bus.time_ms     = time_ms_reg;
    assign bus.valid       = valid_reg;
    assign bus.false_start = false_start_reg;
    assign bus.timeout     = timeout_reg;
endmodule

// File: tb/tb_reaction_sequencer.sv
// Randomized self-checking bench: each trial's outcome is predicted from edge arithmetic.
module tb_reaction_sequencer;
    import reaction_pkg::*;

    localparam int T     = 4;
    localparam int BASE  = 2;
    localparam int STEP  = 1;
    localparam int MAXMS = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    reaction_sequencer_if bus();

    reaction_sequencer #(
        .TICKS_PER_MS (T),
        .BASE_MS      (BASE),
        .STEP_MS      (STEP),
        .MAX_MS       (MAXMS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed word: {time_ms, lamp, busy, valid, false_start, timeout}
    function automatic logic [31:0] observed();
        return 32'({bus.time_ms, bus.lamp, bus.busy, bus.valid, bus.false_start, bus.timeout});
    endfunction

    function automatic logic [31:0] expect_word(input int tm, input bit lamp, input bit busy,
                                                input bit v, input bit fs, input bit to);
        return 32'({14'(tm), lamp, busy, v, fs, to});
    endfunction

    // press = edge index (start edge is 0) at which btn is first sampled high; 0 = never.
    task automatic run_trial(input int id, input int rnd_v, input int press, input bit noise);
        int target;
        int lamp_edge;
        int end_edge;
        int tm;
        bit fs;
        bit v;
        bit to;
        target    = BASE + rnd_v * STEP;
        lamp_edge = target * T + 1;
        fs = 0; v = 0; to = 0;
        if (press != 0 && press <= lamp_edge) begin
            fs = 1; end_edge = press; tm = 0;
        end else if (press != 0 && press <= lamp_edge + MAXMS * T + 1) begin
            v = 1; end_edge = press; tm = (press - 1 - lamp_edge) / T;
        end else begin
            to = 1; end_edge = lamp_edge + MAXMS * T + 1; tm = MAXMS;
        end
        for (int e = 0; e <= end_edge; e++) begin
            bus.start = (e == 0) ? 1'b1 : (noise && $urandom_range(0, 3) == 0);
            bus.rnd   = (e == 0) ? 4'(rnd_v) : 4'($urandom_range(0, 15));
            bus.btn   = (press != 0 && e >= press);
            @(posedge clk); #1;
            if (e < end_edge)
                check($sformatf("t%0d_e%0d", id, e), observed(),
                      expect_word(0, !fs && e >= lamp_edge, 1'b1, 1'b0, 1'b0, 1'b0));
            else
                check($sformatf("t%0d_done", id), observed(),
                      expect_word(tm, 1'b0, 1'b0, v, fs, to));
        end
        bus.start = 1'b0;
        bus.btn   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("t%0d_hold", id), observed(), expect_word(tm, 1'b0, 1'b0, v, fs, to));
        $display("[TB] trial %0d rnd=%0d press=%0d -> time=%0d valid=%0b fs=%0b to=%0b",
                 id, rnd_v, press, tm, v, fs, to);
    endtask

    initial begin
        int mode;
        int r;
        int tgt;
        int le;
        bus.start = 1'b0;
        bus.btn   = 1'b0;
        bus.rnd   = 4'd0;
        #1;
        check("reset_state", observed(), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", observed(), 32'd0);

        run_trial(1, 3, 50, 1'b0);                   // nominal, time 7
        run_trial(2, 15, 10, 1'b0);                  // false start
        run_trial(3, 0, 0, 1'b0);                    // timeout
        run_trial(4, 2, 0, 1'b1);                    // start pulses ignored mid-run
        run_trial(5, 1, 30, 1'b1);                   // restart from DONE, rnd=1
        run_trial(6, 0, 9 + MAXMS * T + 1, 1'b0);    // press on the MAX_MS cycle
        run_trial(7, 4, 1, 1'b0);                    // button held at start

        // Asynchronous reset while the lamp is lit.
        bus.start = 1'b1;
        bus.rnd   = 4'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("lamp_before_reset", observed(), expect_word(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_clears", observed(), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_until_start", observed(), 32'd0);
        $display("[TB] reset mid-lamp done");

        for (int i = 0; i < 25; i++) begin
            r    = $urandom_range(0, 15);
            tgt  = BASE + r * STEP;
            le   = tgt * T + 1;
            mode = $urandom_range(0, 2);
            if (mode == 0)
                run_trial(100 + i, r, $urandom_range(1, le), 1'b1);
            else if (mode == 1)
                run_trial(100 + i, r, $urandom_range(le + 1, le + MAXMS * T + 1), 1'b1);
            else
                run_trial(100 + i, r, 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reaction_sequencer.md
Name: reaction_sequencer

Overview:
- Consumer of the 4-bit pseudorandom value produced by the team's LFSR generator.
- On start, samples the random value and converts it to a random foreperiod in milliseconds, then lights the lamp and measures the player's reaction time in ms.
- Reports false starts (press before the lamp) and timeouts.
- Sits between the LFSR, the debounced button and the BCD display path of the reaction timer.

Parameters:
- TICKS_PER_MS, 50000, clk cycles per millisecond; must be >= 2.
- BASE_MS, 1000, minimum foreperiod in ms.
- STEP_MS, 250, ms added per unit of rnd. Constraint: BASE_MS + 15*STEP_MS <= 16383.
- MAX_MS, 9999, reaction timeout in ms; must be >= 1 and <= 16383.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle start request, synchronous to clk
- btn  in  1  debounced, synchronized button level; 1 = pressed
- rnd  in  4  pseudorandom value from the LFSR
- lamp  out  1  stimulus lamp; 1 = on
- busy  out  1  high in DELAY and LAMP
- time_ms  out  14  measured reaction time in ms
- valid  out  1  time_ms holds a good measurement
- false_start  out  1  button was pressed during the foreperiod
- timeout  out  1  no press within MAX_MS

Behaviour:
- Clock and reset:
  - One clock domain.
  - reset_n is asynchronous and active-low. Assertion forces state=IDLE and clears all counters and outputs: lamp=0, busy=0, time_ms=0, valid=0, false_start=0, timeout=0.
  - This applies mid-operation too; no result is retained across reset.
- Millisecond prescaler:
  - pre counts 0..TICKS_PER_MS-1 while in DELAY or LAMP.
  - When pre==TICKS_PER_MS-1, pre wraps to 0 and ms_cnt (14 bit) increments.
  - pre and ms_cnt are cleared on every entry to DELAY and to LAMP.
- IDLE:
  - All outputs low.
  - start=1 -> DELAY. On the same edge, latch target = BASE_MS + rnd*STEP_MS (14-bit unsigned; no overflow by the parameter constraint).
- DELAY:
  - busy=1, lamp=0.
  - Priority 1: btn=1 -> DONE with false_start=1, time_ms=0.
  - Priority 2: else if ms_cnt==target -> LAMP. lamp rises exactly target*TICKS_PER_MS+1 clk edges after the start-sampling edge.
- LAMP:
  - busy=1, lamp=1.
  - Priority 1: btn=1 -> DONE with time_ms=ms_cnt, valid=1. valid appears on the edge after btn is first sampled high.
  - Priority 2: else if ms_cnt==MAX_MS -> DONE with time_ms=MAX_MS, timeout=1.
  - A press on the same cycle as the MAX_MS condition counts as valid.
- DONE:
  - lamp=0, busy=0.
  - Result outputs hold until the next start or reset.
  - start=1 -> DELAY: clears valid, false_start, timeout and time_ms, and latches a new target from rnd.
- start in DELAY or LAMP is ignored.
- btn already held when start arrives -> false start on the next edge.
- Exactly one of valid, false_start, timeout is high in DONE; none is high elsewhere.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Package reaction_pkg:
  - state enum {IDLE, DELAY, LAMP, DONE}
  - MS_W=14
  - ms_t typedef logic [MS_W-1:0]
- One sub-module: ms_prescaler.
  - Ports: clk, reset_n, clear, en, ms_tick.
  - Owns pre and emits a one-cycle ms_tick.
  - ms_cnt and the FSM stay in reaction_sequencer.

Test Plan:
All scenarios use TICKS_PER_MS=4, BASE_MS=2, STEP_MS=1, MAX_MS=10.
1. Nominal: rnd=3 at start -> lamp rises 21 edges after start (target=5). btn=1 after ms_cnt reaches 7 -> DONE with time_ms=7, valid=1, busy=0, lamp=0.
2. False start: rnd=15 (target=17), btn=1 at 10 cycles after start -> false_start=1, time_ms=0, lamp never high.
3. Timeout: rnd=0 (target=2), no press -> lamp high for 10*4+1 cycles, then timeout=1, time_ms=10, lamp=0.
4. Restart and ignore:
   - start pulses during DELAY and LAMP -> no effect on timing.
   - start in DONE -> flags clear on the same edge, new target latched from current rnd=1 -> lamp after 13 edges.
5. Reset mid-LAMP: reset_n=0 asynchronously between edges -> all outputs 0 immediately. After release, block stays in IDLE until start.
6. Boundary press: btn=1 on the cycle ms_cnt==MAX_MS -> valid=1, time_ms=10, timeout=0.
